// File: rtl/program_sequencer.sv
// program_sequencer: fetch-side controller for the 16-bit CPU instruction memory.
// Maps a program-select command to a slot base address and walks the fetch
// address until the program's terminal OUT instruction. It then drains the
// pipeline with NOPs and signals completion. A fetch-count watchdog aborts
// programs that never reach a terminal instruction.
// Optional feature macro: SEQ_STEP_EN (single-step mode gated by 'step').
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a program-select command (cmd_ready=1)
// LOAD   | pipeline flush, fetch address loaded with the slot base
// FETCH  | fetching sequentially, watching for terminal opcode / watchdog
// DRAIN  | PC frozen, NOPs injected to empty the pipeline
// DONE   | one-cycle completion pulse, then back to IDLE

module program_sequencer #(
    parameter int PC_W         = 16,
    parameter int SLOT_STRIDE  = 100,
    parameter int NUM_SLOTS    = 9,
    parameter int DRAIN_CYCLES = 3,
    parameter int MAX_LEN      = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cmd_valid,
    input  logic [3:0]      cmd_sel,
    output logic            cmd_ready,
    input  logic [15:0]     M_instruction,
    output logic [PC_W-1:0] PCAdd_pc,
    output logic            run,
    output logic            flush,
    output logic            nop_inject,
    output logic            busy,
    output logic            done_pulse,
    output logic            err_pulse,
    output logic [1:0]      err_code,
    input  logic            step
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(MAX_LEN - 1);
    localparam logic [DRN_W-1:0] DRN_INIT = DRN_W'(DRAIN_CYCLES);
    localparam logic [3:0]       SEL_MAX  = 4'(NUM_SLOTS);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_SEL  = 2'b01;
    localparam logic [1:0] ERR_WDOG = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    logic [PC_W-1:0]  base;
    logic [CNT_W-1:0] fetch_cnt;
    logic [DRN_W-1:0] drain_cnt;
    logic             run_r;
    logic             nop_r;
    logic             adv;
    logic             terminal;
    logic             sel_ok;
    logic             unused_inputs;

    assign terminal = (M_instruction[15:12] == 4'b0001);
    assign sel_ok   = (cmd_sel != 4'd0) && (cmd_sel <= SEL_MAX);

    // Only the opcode nibble matters here; step is consumed only in step mode.
    assign unused_inputs = ^{step, M_instruction[11:0]};

`ifdef SEQ_STEP_EN
    // Single-step: fetch progress and the fetch/NOP strobes follow 'step'.
    assign adv        = step;
    assign run        = run_r & step;
    assign nop_inject = nop_r & step;
`else
    assign adv        = 1'b1;
    assign run        = run_r;
    assign nop_inject = nop_r;
`endif

    // Handshake and status decoded from the registered state.
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    // Sequencer FSM with registered strobes aligned to the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            base       <= '0;
            PCAdd_pc   <= '0;
            fetch_cnt  <= '0;
            drain_cnt  <= '0;
            run_r      <= 1'b0;
            nop_r      <= 1'b0;
            flush      <= 1'b0;
            done_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            flush      <= 1'b0;
            done_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (sel_ok) begin
                            base     <= PC_W'(32'(cmd_sel) * SLOT_STRIDE);
                            err_code <= ERR_NONE;
                            flush    <= 1'b1;
                            state    <= S_LOAD;
                        end else begin
                            err_pulse <= 1'b1;
                            err_code  <= ERR_SEL;
                        end
                    end
                end
                S_LOAD: begin
                    PCAdd_pc  <= base;
                    fetch_cnt <= '0;
                    run_r     <= 1'b1;
                    state     <= S_FETCH;
                end
                S_FETCH: begin
                    if (adv) begin
                        PCAdd_pc  <= PCAdd_pc + 1'b1;
                        fetch_cnt <= fetch_cnt + 1'b1;
                        // Terminal has priority over the watchdog on the last allowed fetch.
                        if (terminal) begin
                            if (DRAIN_CYCLES == 0) begin
                                run_r      <= 1'b0;
                                done_pulse <= 1'b1;
                                state      <= S_DONE;
                            end else begin
                                drain_cnt <= DRN_INIT;
                                nop_r     <= 1'b1;
                                state     <= S_DRAIN;
                            end
                        end else if (fetch_cnt == WD_LAST) begin
                            run_r     <= 1'b0;
                            err_pulse <= 1'b1;
                            err_code  <= ERR_WDOG;
                            flush     <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (adv) begin
                        drain_cnt <= drain_cnt - 1'b1;
                        if (drain_cnt == DRN_W'(1)) begin
                            run_r      <= 1'b0;
                            nop_r      <= 1'b0;
                            done_pulse <= 1'b1;
                            state      <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    run_r <= 1'b0;
                    nop_r <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: table of program-select commands with expected
// outcomes, plus hand-written sequences for reset values and mid-run reset.
`timescale 1ns/1ps

module tb_program_sequencer;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic [3:0]  cmd_sel;
    logic        cmd_ready;
    logic [15:0] M_instruction;
    logic [15:0] PCAdd_pc;
    logic        run;
    logic        flush;
    logic        nop_inject;
    logic        busy;
    logic        done_pulse;
    logic        err_pulse;
    logic [1:0]  err_code;
    logic        step;

    int errors = 0;
    int checks = 0;
    int exp_pc = 0;
    bit pc_known = 1'b1;

    typedef struct {
        logic [3:0] sel;
        bit         bad;
        bit         wdog;
        int         fetches;
        bit         poke;
    } vec_t;

    vec_t vecs[10];

    program_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_sel       (cmd_sel),
        .cmd_ready     (cmd_ready),
        .M_instruction (M_instruction),
        .PCAdd_pc      (PCAdd_pc),
        .run           (run),
        .flush         (flush),
        .nop_inject    (nop_inject),
        .busy          (busy),
        .done_pulse    (done_pulse),
        .err_pulse     (err_pulse),
        .err_code      (err_code),
        .step          (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: terminal OUT opcode (0001) only at these addresses.
    // Other words carry 1-nibbles outside the opcode field on purpose.
    always_comb begin
        case (PCAdd_pc)
            16'd107, 16'd210, 16'd310, 16'd400, 16'd631, 16'd707, 16'd910:
                M_instruction = 16'h1A5C;
            default:
                M_instruction = 16'h2111;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic do_cmd(input vec_t v);
        int base;
        int n;
        int d;
        int guard;
        base = int'(v.sel) * 100;
        chk("idle_ready", 32'(cmd_ready), 1);
        chk("idle_busy", 32'(busy), 0);
        cmd_valid = 1'b1;
        cmd_sel   = v.sel;
        tick();
        cmd_valid = 1'b0;
        if (v.bad) begin
            chk("bad_err_pulse", 32'(err_pulse), 1);
            chk("bad_err_code", 32'(err_code), 1);
            chk("bad_busy", 32'(busy), 0);
            chk("bad_flush", 32'(flush), 0);
            if (pc_known) chk("bad_pc_hold", 32'(PCAdd_pc), 32'(exp_pc));
            tick();
            chk("bad_pulse_clr", 32'(err_pulse), 0);
            chk("bad_code_hold", 32'(err_code), 1);
            chk("bad_busy_after", 32'(busy), 0);
            return;
        end
        chk("load_flush", 32'(flush), 1);
        chk("load_busy", 32'(busy), 1);
        chk("load_ready", 32'(cmd_ready), 0);
        chk("load_code", 32'(err_code), 0);
        chk("load_run", 32'(run), 0);
        tick();
        n = 0;
        guard = 0;
        while (run && !nop_inject && guard < 100) begin
            chk("fetch_pc", 32'(PCAdd_pc), 32'(base + n));
            chk("fetch_err", 32'(err_pulse), 0);
            chk("fetch_flush", 32'(flush), 0);
            if (v.poke) begin
                cmd_valid = 1'b1;
                cmd_sel   = 4'd3;
            end
            n++;
            guard++;
            tick();
        end
        cmd_valid = 1'b0;
        if (guard >= 100) timeout("fetch_loop");
        chk("fetch_count", 32'(n), 32'(v.fetches));
        if (v.wdog) begin
            chk("wd_err_pulse", 32'(err_pulse), 1);
            chk("wd_err_code", 32'(err_code), 2);
            chk("wd_flush", 32'(flush), 1);
            chk("wd_busy", 32'(busy), 0);
            chk("wd_done", 32'(done_pulse), 0);
            tick();
            chk("wd_pulse_clr", 32'(err_pulse), 0);
            chk("wd_flush_clr", 32'(flush), 0);
            chk("wd_code_hold", 32'(err_code), 2);
            pc_known = 1'b0;
            return;
        end
        d = 0;
        guard = 0;
        while (nop_inject && guard < 20) begin
            chk("drain_pc", 32'(PCAdd_pc), 32'(base + v.fetches));
            chk("drain_run", 32'(run), 1);
            d++;
            guard++;
            tick();
        end
        if (guard >= 20) timeout("drain_loop");
        chk("drain_count", 32'(d), 3);
        chk("done_pulse", 32'(done_pulse), 1);
        chk("done_busy", 32'(busy), 1);
        chk("done_run", 32'(run), 0);
        chk("done_pc", 32'(PCAdd_pc), 32'(base + v.fetches));
        chk("done_err", 32'(err_pulse), 0);
        chk("done_code", 32'(err_code), 0);
        tick();
        chk("done_clr", 32'(done_pulse), 0);
        chk("end_busy", 32'(busy), 0);
        chk("end_ready", 32'(cmd_ready), 1);
        chk("end_pc_hold", 32'(PCAdd_pc), 32'(base + v.fetches));
        exp_pc   = base + v.fetches;
        pc_known = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"}, 32'(PCAdd_pc), 0);
        chk({tag, "_run"}, 32'(run), 0);
        chk({tag, "_flush"}, 32'(flush), 0);
        chk({tag, "_nop"}, 32'(nop_inject), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_ready"}, 32'(cmd_ready), 1);
        chk({tag, "_done"}, 32'(done_pulse), 0);
        chk({tag, "_err"}, 32'(err_pulse), 0);
        chk({tag, "_code"}, 32'(err_code), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int guard;
        vec_t v;
        //         sel    bad   wdog  fetches poke
        vecs[0] = '{4'd1,  1'b0, 1'b0, 8,  1'b0};  // 100..107, terminal at 107
        vecs[1] = '{4'd3,  1'b0, 1'b0, 11, 1'b0};  // 300..310
        vecs[2] = '{4'd9,  1'b0, 1'b0, 11, 1'b0};  // 900..910, top slot
        vecs[3] = '{4'd0,  1'b1, 1'b0, 0,  1'b0};  // below range
        vecs[4] = '{4'd10, 1'b1, 1'b0, 0,  1'b0};  // above range
        vecs[5] = '{4'd4,  1'b0, 1'b0, 1,  1'b0};  // terminal on first fetch
        vecs[6] = '{4'd15, 1'b1, 1'b0, 0,  1'b0};
        vecs[7] = '{4'd6,  1'b0, 1'b0, 32, 1'b0};  // terminal on last allowed fetch wins
        vecs[8] = '{4'd5,  1'b0, 1'b1, 32, 1'b0};  // no terminal: watchdog 500..531
        vecs[9] = '{4'd1,  1'b0, 1'b0, 8,  1'b1};  // cmd_valid held during FETCH

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_sel   = 4'd0;
        step      = 1'b0;
        tick();
        tick();
        chk_reset_vals("rst");
        reset_n = 1'b1;
        tick();
        chk_reset_vals("post_rst");

        for (int i = 0; i < 10; i++) begin
            do_cmd(vecs[i]);
        end

        // Reset in the middle of a fetch run.
        cmd_valid = 1'b1;
        cmd_sel   = 4'd2;
        tick();
        cmd_valid = 1'b0;
        guard = 0;
        while (PCAdd_pc != 16'd204 && guard < 40) begin
            guard++;
            tick();
        end
        if (guard >= 40) timeout("wait_pc_204");
        chk("mid_busy", 32'(busy), 1);
        chk("mid_run", 32'(run), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        tick();
        chk_reset_vals("held_rst");
        reset_n = 1'b1;
        tick();
        chk("after_rst_done", 32'(done_pulse), 0);
        chk("after_rst_err", 32'(err_pulse), 0);
        chk("after_rst_busy", 32'(busy), 0);
        exp_pc   = 0;
        pc_known = 1'b1;

        v = '{4'd7, 1'b0, 1'b0, 8, 1'b0};
        do_cmd(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
